// File: rtl/line_clear_sequencer.sv
// Tetris line-clear sequencer: removes every full row, lowest first, by
// collapsing the playfield one row per cycle, then reports the line count.

module first_high_index #(
  parameter int W  = 20,
  parameter int IW = 5
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Lowest set bit wins: the descending scan overwrites with lower hits.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

module line_clear_sequencer #(
  parameter int COLS    = 10,
  parameter int TOTAL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [19:0]        full_rows,
  output logic [4:0]         rd_addr,
  input  logic [COLS-1:0]    rd_data,
  output logic               wr_en,
  output logic [4:0]         wr_addr,
  output logic [COLS-1:0]    wr_data,
  output logic               busy,
  output logic               done,
  output logic [4:0]         lines_cleared,
  output logic [TOTAL_W-1:0] total_lines
);

  localparam int SW = ((TOTAL_W > 5) ? TOTAL_W : 5) + 1;
  localparam logic [SW-1:0] TOT_MAX = SW'({TOTAL_W{1'b1}});

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FIND      = 3'd1,
    S_SHIFT     = 3'd2,
    S_CLEAR_TOP = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [19:0]          mask_q, mask_d;
  logic [4:0]           k_q, k_d;
  logic [4:0]           ptr_q, ptr_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [4:0]           lines_q, lines_d;
  logic [TOTAL_W-1:0]   total_q, total_d;

  logic [4:0]           fhi_idx;
  logic                 fhi_found;
  logic [19:0]          mask_collapsed;
  logic [SW-1:0]        total_sum;

  first_high_index #(.W(20), .IW(5)) u_fhi (
    .vec   (mask_q),
    .idx   (fhi_idx),
    .found (fhi_found)
  );

  // Drop row k from the mask: bits above k slide down, bit 19 empties.
  always_comb begin
    mask_collapsed = 20'd0;
    for (int i = 0; i < 19; i++) begin
      if (5'(i) < k_q) begin
        mask_collapsed[i] = mask_q[i];
      end else begin
        mask_collapsed[i] = mask_q[i+1];
      end
    end
  end

  assign total_sum = SW'(total_q) + SW'(cnt_q);

  // Next-state and playfield port control.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    k_d     = k_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    total_d = total_q;
    rd_addr = 5'd0;
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = full_rows;
          cnt_d   = 5'd0;
          state_d = (full_rows == 20'd0) ? S_DONE : S_FIND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FIND: begin
        k_d   = fhi_idx;
        ptr_d = fhi_idx;
        if (!fhi_found) begin
          state_d = S_DONE;
        end else if (fhi_idx < 5'd19) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_CLEAR_TOP;
        end
      end
      S_SHIFT: begin
        rd_addr = ptr_q + 5'd1;
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        wr_data = rd_data;
        ptr_d   = ptr_q + 5'd1;
        state_d = (ptr_q == 5'd18) ? S_CLEAR_TOP : S_SHIFT;
      end
      S_CLEAR_TOP: begin
        wr_en   = 1'b1;
        wr_addr = 5'd19;
        wr_data = '0;
        mask_d  = mask_collapsed;
        cnt_d   = (cnt_q == 5'd20) ? cnt_q : cnt_q + 5'd1;
        state_d = (mask_collapsed != 20'd0) ? S_FIND : S_DONE;
      end
      S_DONE: begin
        lines_d = cnt_q;
        total_d = (total_sum > TOT_MAX) ? {TOTAL_W{1'b1}} : total_sum[TOTAL_W-1:0];
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= 20'd0;
      k_q     <= 5'd0;
      ptr_q   <= 5'd0;
      cnt_q   <= 5'd0;
      lines_q <= 5'd0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      k_q     <= k_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      total_q <= total_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign lines_cleared = lines_q;
  assign total_lines   = total_q;

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Randomized bench for line_clear_sequencer with a playfield memory model and
// a reference that derives the final board, timing and counts from the row mask.

module tb_line_clear_sequencer;

  localparam int COLS    = 10;
  localparam int TOTAL_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n, start;
  logic [19:0]         full_rows;
  logic [4:0]          rd_addr, wr_addr, lines_cleared;
  logic [COLS-1:0]     rd_data, wr_data;
  logic                wr_en, busy, done;
  logic [TOTAL_W-1:0]  total_lines;

  logic [4:0]          b_rd_addr, b_wr_addr, b_lines;
  logic [COLS-1:0]     b_rd_data, b_wr_data;
  logic                b_wr_en, b_busy, b_done;
  logic [2:0]          b_total;

  logic [COLS-1:0]     board [20];

  int n_cmp = 0;
  int n_bad = 0;
  int model_total  = 0;
  int model_total3 = 0;

  line_clear_sequencer #(.COLS(COLS), .TOTAL_W(TOTAL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .full_rows(full_rows),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .total_lines(total_lines)
  );

  // Narrow-total instance sharing the control inputs, used for saturation.
  line_clear_sequencer #(.COLS(COLS), .TOTAL_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .full_rows(full_rows),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .busy(b_busy), .done(b_done),
    .lines_cleared(b_lines), .total_lines(b_total)
  );

  assign rd_data   = (rd_addr < 5'd20) ? board[rd_addr] : '0;
  assign b_rd_data = '0;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] pack(input logic [COLS-1:0] b [20]);
    logic [199:0] v;
    v = '0;
    for (int r = 0; r < 20; r++) v[r*COLS +: COLS] = b[r];
    return v;
  endfunction

  task automatic run_seq(input logic [19:0] m, input bit inject);
    logic [COLS-1:0] exp_b [20];
    logic [COLS-1:0] pend_d;
    logic [4:0]      pend_a;
    logic            pend_e;
    int j, idx, cyc, wrs, nl, c, wcount;
    // Reference: survivors keep their order and drop to the bottom.
    j = 0;
    for (int r = 0; r < 20; r++) begin
      if (!m[r]) begin
        exp_b[j] = board[r];
        j++;
      end
    end
    for (int r = j; r < 20; r++) exp_b[r] = '0;
    // The i-th full row (ascending) sits at row r-i when it is reached.
    cyc = 1; wrs = 0; idx = 0;
    for (int r = 0; r < 20; r++) begin
      if (m[r]) begin
        cyc += 21 - (r - idx);
        wrs += 20 - (r - idx);
        idx++;
      end
    end
    nl = idx;
    model_total  = (model_total + nl > 65535) ? 65535 : model_total + nl;
    model_total3 = (model_total3 + nl > 7) ? 7 : model_total3 + nl;

    start = 1'b1; full_rows = m;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1; wcount = 0;
    chk("busy_rise", 200'(busy), 200'(1'b1));
    while (done !== 1'b1 && c < 2000) begin
      if (c == 2) start = 1'b0;
      if (inject && c == 1) begin
        start = 1'b1;
        full_rows = 20'($urandom);
      end
      pend_e = wr_en; pend_a = wr_addr; pend_d = wr_data;
      @(posedge clk);
      if (pend_e === 1'b1) begin
        wcount++;
        if (pend_a < 5'd20) board[pend_a] = pend_d;
      end
      c++;
      #1;
    end
    start = 1'b0;
    chk("done_cycle", 200'(c), 200'(cyc));
    @(posedge clk); #1;
    chk("done_pulse", 200'(done), 200'(1'b0));
    chk("busy_fall", 200'(busy), 200'(1'b0));
    chk("lines", 200'(lines_cleared), 200'(nl));
    chk("total", 200'(total_lines), 200'(model_total));
    chk("total_sat", 200'(b_total), 200'(model_total3));
    chk("writes", 200'(wcount), 200'(wrs));
    chk("board", pack(board), pack(exp_b));
  endtask

  task automatic fill_random();
    for (int r = 0; r < 20; r++) board[r] = COLS'($urandom);
  endtask

  function automatic logic [19:0] rand_mask();
    logic [19:0] m;
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0: m = 20'd1 << $urandom_range(0, 19);
      1: begin
        m = 20'd0;
        for (int i = 0; i < 4; i++) m |= 20'd1 << $urandom_range(0, 19);
      end
      2: m = 20'($urandom);
      default: m = 20'hF << $urandom_range(0, 16);
    endcase
    return m;
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; full_rows = 20'd0;
    for (int r = 0; r < 20; r++) board[r] = COLS'(r + 1);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", 200'(busy), 200'(1'b0));
    chk("rst_done", 200'(done), 200'(1'b0));
    chk("rst_wr_en", 200'(wr_en), 200'(1'b0));
    chk("rst_ports", {rd_addr, wr_addr, wr_data}, 200'd0);
    chk("rst_lines", 200'(lines_cleared), 200'd0);
    chk("rst_total", 200'(total_lines), 200'd0);

    run_seq(20'h00000, 1'b0);
    for (int r = 0; r < 20; r++) board[r] = COLS'(r + 1);
    run_seq(20'h00001, 1'b0);
    fill_random();
    run_seq(20'h80000, 1'b0);
    for (int r = 0; r < 20; r++) board[r] = COLS'(r + 1);
    run_seq(20'h0000F, 1'b1);
    for (int r = 0; r < 20; r++) board[r] = COLS'(r + 1);
    run_seq(20'h00104, 1'b1);
    fill_random();
    run_seq(20'hFFFFF, 1'b0);

    for (int t = 0; t < 30; t++) begin
      fill_random();
      run_seq(rand_mask(), 1'($urandom_range(0, 1)));
    end

    // Abort a sequence partway through the shift phase.
    fill_random();
    start = 1'b1; full_rows = 20'h00001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_abort_wr_en", 200'(wr_en), 200'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 200'(busy), 200'(1'b0));
    chk("abort_wr_en", 200'(wr_en), 200'(1'b0));
    chk("abort_total", 200'(total_lines), 200'd0);
    chk("abort_total_sat", 200'(b_total), 200'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_total = 0; model_total3 = 0;

    for (int t = 0; t < 4; t++) begin
      fill_random();
      run_seq(rand_mask(), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
